// File: rtl/collision_tracker_pkg.sv
// rtl/collision_tracker_pkg.sv - shared state encoding and default constants for the collision tracker
package collision_tracker_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_INVINC = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam int DEF_N_BLOCKS   = 6;
    localparam int DEF_POS_W      = 10;
    localparam int DEF_LANE_W     = 2;
    localparam int DEF_HIT_TOP    = 380;
    localparam int DEF_HIT_BOT    = 480;
    localparam int DEF_LIVES      = 3;
    localparam int DEF_INV_FRAMES = 60;

endpackage

// File: rtl/collision_tracker_hit_window_cmp.sv
// rtl/collision_tracker_hit_window_cmp.sv - single block window and lane overlap compare
module hit_window_cmp
    import collision_tracker_pkg::*;
#(
    parameter int POS_W   = DEF_POS_W,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int HIT_TOP = DEF_HIT_TOP,
    parameter int HIT_BOT = DEF_HIT_BOT
) (
    input  logic [POS_W-1:0]  pos,
    input  logic [LANE_W-1:0] lane,
    input  logic [LANE_W-1:0] people,
    output logic              overlap
);

    // Both window bounds are exclusive; positions are unsigned.
    always_comb begin
        overlap = (pos > POS_W'(HIT_TOP)) && (pos < POS_W'(HIT_BOT)) && (lane == people);
    end

endmodule

// File: rtl/collision_tracker.sv
// rtl/collision_tracker.sv - block/player collision detection with lives and invincibility window
module collision_tracker
    import collision_tracker_pkg::*;
#(
    parameter int N_BLOCKS   = DEF_N_BLOCKS,
    parameter int POS_W      = DEF_POS_W,
    parameter int LANE_W     = DEF_LANE_W,
    parameter int HIT_TOP    = DEF_HIT_TOP,
    parameter int HIT_BOT    = DEF_HIT_BOT,
    parameter int LIVES      = DEF_LIVES,
    parameter int INV_FRAMES = DEF_INV_FRAMES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         active,
    input  logic                         frame_tick,
    input  logic                         restart,
    input  logic [N_BLOCKS*POS_W-1:0]    pos_blocks,
    input  logic [N_BLOCKS*LANE_W-1:0]   lanes,
    input  logic [LANE_W-1:0]            people,
    output logic                         hit_now,
    output logic                         hit_pulse,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic                         invincible,
    output logic                         game_over
);

    localparam int LIFE_W = $clog2(LIVES + 1);
    localparam int CNT_W  = (INV_FRAMES < 1) ? 1 : $clog2(INV_FRAMES + 1);

    logic [N_BLOCKS-1:0] overlap;

    logic              hit_now_q,   hit_now_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic [LIFE_W-1:0] lives_q,     lives_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    state_t            state_q,     state_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_BLOCKS; gi++) begin : g_cmp
            hit_window_cmp #(
                .POS_W   (POS_W),
                .LANE_W  (LANE_W),
                .HIT_TOP (HIT_TOP),
                .HIT_BOT (HIT_BOT)
            ) u_cmp (
                .pos     (pos_blocks[gi*POS_W +: POS_W]),
                .lane    (lanes[gi*LANE_W +: LANE_W]),
                .people  (people),
                .overlap (overlap[gi])
            );
        end
    endgenerate

    // Any overlapping block counts as a single hit; detection is blanked outside gameplay.
    always_comb begin
        hit_now_d = active & (|overlap);
    end

    // Next-state logic: restart wins over everything but reset; inactive scenes freeze the game.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        hit_pulse_d = 1'b0;
        if (restart) begin
            state_d = ST_PLAY;
            lives_d = LIFE_W'(LIVES);
            cnt_d   = '0;
        end else if (active) begin
            case (state_q)
                ST_PLAY: begin
                    if (hit_now_q) begin
                        hit_pulse_d = 1'b1;
                        if (lives_q <= LIFE_W'(1)) begin
                            lives_d = '0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - LIFE_W'(1);
                            cnt_d   = CNT_W'(INV_FRAMES);
                            state_d = (INV_FRAMES == 0) ? ST_PLAY : ST_INVINC;
                        end
                    end
                end
                ST_INVINC: begin
                    if (frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_PLAY;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_now_q   <= 1'b0;
            hit_pulse_q <= 1'b0;
            lives_q     <= LIFE_W'(LIVES);
            cnt_q       <= '0;
            state_q     <= ST_PLAY;
        end else begin
            hit_now_q   <= hit_now_d;
            hit_pulse_q <= hit_pulse_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    assign hit_now    = hit_now_q;
    assign hit_pulse  = hit_pulse_q;
    assign lives      = lives_q;
    assign invincible = (state_q == ST_INVINC);
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_collision_tracker.sv
// tb/tb_collision_tracker.sv - scoreboard bench for collision_tracker
module tb_collision_tracker;

    localparam int NB = 6;
    localparam int PW = 10;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           active;
    logic           frame_tick;
    logic           restart;
    logic [NB*PW-1:0] pos_blocks;
    logic [NB*LW-1:0] lanes;
    logic [LW-1:0]  people;
    logic           hit_now;
    logic           hit_pulse;
    logic [1:0]     lives;
    logic           invincible;
    logic           game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lives;
        int inv;
        int over;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    collision_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (active),
        .frame_tick (frame_tick),
        .restart    (restart),
        .pos_blocks (pos_blocks),
        .lanes      (lanes),
        .people     (people),
        .hit_now    (hit_now),
        .hit_pulse  (hit_pulse),
        .lives      (lives),
        .invincible (invincible),
        .game_over  (game_over)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: every hit pulse must match the next expected hit outcome.
    always @(negedge clk) begin
        if (hit_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=1 expected=0 lives=%0d", lives);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_lives", int'(lives), mon_e.lives);
                chk("pulse_invincible", int'(invincible), mon_e.inv);
                chk("pulse_game_over", int'(game_over), mon_e.over);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_block(input int i, input int pos, input int lane);
        pos_blocks[i*PW +: PW] = PW'(pos);
        lanes[i*LW +: LW]      = LW'(lane);
    endtask

    task automatic clear_blocks();
        for (int i = 0; i < NB; i++) set_block(i, 0, 0);
    endtask

    task automatic expect_hit(input int l, input int inv, input int over);
        exp_t e;
        e.lives = l;
        e.inv   = inv;
        e.over  = over;
        exp_q.push_back(e);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick(1);
            frame_tick = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        active     = 1'b1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        people     = 2'd1;
        pos_blocks = '0;
        lanes      = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("reset_lives", int'(lives), 3);
        chk("reset_hit_now", int'(hit_now), 0);
        chk("reset_invincible", int'(invincible), 0);
        chk("reset_game_over", int'(game_over), 0);

        // Exclusive window bounds.
        set_block(0, 380, 1);
        tick(2);
        chk("bound_380", int'(hit_now), 0);
        set_block(0, 480, 1);
        tick(2);
        chk("bound_480", int'(hit_now), 0);
        set_block(0, 0, 0);

        // Basic hit on block 2.
        set_block(2, 400, 1);
        expect_hit(2, 1, 0);
        tick(1);
        chk("hit_latency", int'(hit_now), 1);
        tick(1);
        chk("hit1_invincible", int'(invincible), 1);

        // Overlap held through invincibility.
        frames(59);
        chk("inv_before_last_tick", int'(invincible), 1);
        chk("lives_during_inv", int'(lives), 2);
        expect_hit(1, 1, 0);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        chk("inv_end_play", int'(invincible), 0);
        chk("inv_end_no_pulse", int'(hit_pulse), 0);
        tick(2);
        chk("hit2_lives", int'(lives), 1);

        // Final hit to game over.
        frames(59);
        expect_hit(0, 0, 1);
        frames(1);
        tick(1);
        chk("over_flag", int'(game_over), 1);
        set_block(0, 420, 1);
        set_block(4, 450, 1);
        tick(10);
        chk("over_lives_held", int'(lives), 0);
        clear_blocks();
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_lives", int'(lives), 3);
        chk("restart_play", int'(game_over), 0);

        // 381 is inside the window.
        set_block(0, 381, 1);
        expect_hit(2, 1, 0);
        tick(1);
        chk("bound_381", int'(hit_now), 1);
        tick(1);

        // Restart held across a PLAY cycle with hit_now high beats the hit.
        restart = 1'b1;
        tick(2);
        chk("restart_priority_lives", int'(lives), 3);
        expect_hit(2, 1, 0);
        restart = 1'b0;
        tick(2);

        // Three simultaneous overlaps form one hit.
        clear_blocks();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(2);
        set_block(0, 400, 1);
        set_block(3, 420, 1);
        set_block(5, 450, 1);
        expect_hit(2, 1, 0);
        tick(6);
        chk("multi_lives", int'(lives), 2);

        // Inactive scene suppresses detection.
        restart = 1'b1;
        active  = 1'b0;
        tick(1);
        restart = 1'b0;
        tick(3);
        chk("inactive_hit_now", int'(hit_now), 0);
        chk("inactive_lives", int'(lives), 3);
        active = 1'b1;
        expect_hit(2, 1, 0);
        tick(3);

        // Reset mid-invincibility overrides restart.
        rst_n   = 1'b0;
        restart = 1'b1;
        tick(1);
        chk("rst_lives", int'(lives), 3);
        chk("rst_invincible", int'(invincible), 0);
        chk("rst_hit_now", int'(hit_now), 0);
        rst_n   = 1'b1;
        restart = 1'b0;
        clear_blocks();
        tick(5);
        chk("pending_hits", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
